imem_fetch_ctrl: RTL

//  Fetch sequencer and owner of the instruction memory port for the single-cycle RISC-V core.

---
 rtl/imem_fetch_ctrl_if.sv | 24 ++
 rtl/imem_fetch_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - boot-load stream and instruction memory port bundle
interface imem_fetch_ctrl_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;

  // Boot source and instruction memory side
  modport master (
    output load_valid, load_data, load_last, imem_rdata,
    input  load_ready, imem_we, imem_waddr, imem_wdata, imem_raddr
  );

  // Fetch controller side
  modport slave (
    input  load_valid, load_data, load_last, imem_rdata,
    output load_ready, imem_we, imem_waddr, imem_wdata, imem_raddr
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - boot loader and PC sequencer owning the instruction memory port
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    reset,
  imem_fetch_ctrl_if.slave        bus,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic [31:0]             pc,
  output logic [31:0]             inst_out,
  output logic [31:0]             inst_pc,
  output logic                    inst_valid,
  output logic                    busy_load,
  output logic [1:0]              fault
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] load_cnt;
  logic          accept;
  logic          tgt_misaligned;
  logic          tgt_oor;
  logic [31:0]   pc_inc;
  logic [31:0]   pc_seq;

  // Sequential fetch wraps at the end of memory; redirects never wrap.
  assign pc_inc = pc + 32'd4;
  assign pc_seq = (pc_inc >= PC_LIMIT) ? 32'd0 : pc_inc;

  assign tgt_misaligned = |redirect_pc[1:0];
  assign tgt_oor        = (redirect_pc >= PC_LIMIT);

  assign bus.imem_waddr = {{(30-AW){1'b0}}, load_cnt, 2'b00};
  assign bus.imem_wdata = bus.load_data;
  assign bus.imem_raddr = pc;

  // State register; reset from any state returns to boot loading
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-derived handshake outputs
  always_comb begin
    state_nxt      = state;
    bus.load_ready = 1'b0;
    bus.imem_we    = 1'b0;
    busy_load      = 1'b0;
    accept         = 1'b0;
    case (state)
      S_LOAD: begin
        bus.load_ready = 1'b1;
        busy_load      = 1'b1;
        accept         = bus.load_valid;
        bus.imem_we    = bus.load_valid;
        // All-ones counter means the last memory word: the image is truncated there.
        if (accept && (bus.load_last || (&load_cnt))) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (redirect_valid && (tgt_misaligned || tgt_oor)) begin
          state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // Boot word counter, restarts at word 0 on every reset
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt <= '0;
    end else if (accept) begin
      load_cnt <= load_cnt + AW'(1);
    end
  end

  // PC, decode slot and sticky fault; redirect beats stall beats advance
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      inst_out   <= NOP;
      inst_pc    <= 32'd0;
      inst_valid <= 1'b0;
      fault      <= 2'b00;
    end else if (state == S_RUN) begin
      if (redirect_valid) begin
        inst_out   <= NOP;
        inst_valid <= 1'b0;
        if (tgt_misaligned) begin
          fault <= 2'b01;
        end else if (tgt_oor) begin
          fault <= 2'b10;
        end else begin
          pc <= redirect_pc;
        end
      end else if (!stall) begin
        inst_out   <= bus.imem_rdata;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
        pc         <= pc_seq;
      end
    end
  end

endmodule
